// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the XNOR PRBS generator/checker pair.
//   prbs_state_e - checker FSM states
//   PRBS7_*      - default PRBS7 polynomial x^7+x^6+1
//   is_lockup()  - true when the low 'width' bits of sr are all ones, the one
//                  state an XNOR-feedback LFSR can never leave
package prbs_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

   localparam int PRBS7_W     = 7;
   localparam int PRBS7_TAP_A = 7;
   localparam int PRBS7_TAP_B = 6;

   function automatic logic is_lockup(input logic [63:0] sr, input int width);
      logic all_ones;
      all_ones = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (i < width && !sr[i]) all_ones = 1'b0;
      end
      return all_ones;
   endfunction

endpackage

// File: rtl/prbs_xnor_step.sv
// prbs_xnor_step: combinational XNOR Fibonacci LFSR step, shared by the
// pattern generator and the checker so both ends use one feedback definition.
//   sr      in  LFSR_W  current register (bit 0 is the newest bit)
//   exp_bit out 1       next bit the sequence must produce
//   sr_next out LFSR_W  register after shifting exp_bit in at the LSB
module prbs_xnor_step
   import prbs_pkg::*;
#(
   parameter int LFSR_W = PRBS7_W,
   parameter int TAP_A  = PRBS7_TAP_A,
   parameter int TAP_B  = PRBS7_TAP_B
) (
   input  logic [LFSR_W-1:0] sr,
   output logic              exp_bit,
   output logic [LFSR_W-1:0] sr_next
);

   assign exp_bit = ~(sr[TAP_A-1] ^ sr[TAP_B-1]);
   assign sr_next = {sr[LFSR_W-2:0], exp_bit};

endmodule

// File: rtl/prbs_xnor_checker.sv
// prbs_xnor_checker: serial PRBS receiver. Seeds its LFSR from the incoming
// stream, verifies LOCK_COUNT predicted bits, then flywheels on its own LFSR
// and counts mismatches.
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous, active-high reset
//   din_valid  in  1      din is sampled this cycle; nothing advances otherwise
//   din        in  1      received serial bit
//   locked     out 1      high while in LOCKED
//   err_pulse  out 1      one-cycle pulse per mismatched bit while LOCKED
//   err_count  out ERR_W  saturating mismatch total, cleared only by reset
//   bit_count  out ERR_W  (only with PRBS_CHECKER_BITCNT_EN) saturating count
//                         of valid bits seen while LOCKED, cleared only by reset
//
// Optional build macro: PRBS_CHECKER_BITCNT_EN adds bit_count.
//
// state  | meaning
// HUNT   | shifting din in to (re)seed the LFSR, fill counts bits loaded
// VERIFY | predicting each bit from din-seeded sr, run counts matches
// LOCKED | flywheel on own LFSR, miss counts consecutive mismatches
module prbs_xnor_checker
   import prbs_pkg::*;
#(
   parameter int LFSR_W      = PRBS7_W,
   parameter int TAP_A       = PRBS7_TAP_A,
   parameter int TAP_B       = PRBS7_TAP_B,
   parameter int LOCK_COUNT  = 16,
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din_valid,
   input  logic             din,
   output logic             locked,
   output logic             err_pulse,
`ifdef PRBS_CHECKER_BITCNT_EN
   output logic [ERR_W-1:0] err_count,
   output logic [ERR_W-1:0] bit_count
`else
   output logic [ERR_W-1:0] err_count
`endif
);

   localparam int FILL_W = $clog2(LFSR_W + 1);
   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_THRESH + 1);

   // Compare against the pre-increment value so the transition happens on
   // the bit that makes the count reach its target.
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

   prbs_state_e        state_q, state_d;
   logic [LFSR_W-1:0]  sr_q, sr_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic               err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
`ifdef PRBS_CHECKER_BITCNT_EN
   logic [ERR_W-1:0]   bit_count_q, bit_count_d;
`endif

   logic               exp_bit;
   logic [LFSR_W-1:0]  sr_fly;
   logic [LFSR_W-1:0]  sr_din;
   logic               lockup;

   prbs_xnor_step #(
      .LFSR_W (LFSR_W),
      .TAP_A  (TAP_A),
      .TAP_B  (TAP_B)
   ) u_step (
      .sr      (sr_q),
      .exp_bit (exp_bit),
      .sr_next (sr_fly)
   );

   assign sr_din = {sr_q[LFSR_W-2:0], din};
   assign lockup = is_lockup(64'(sr_q), LFSR_W);

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      run_d       = run_q;
      miss_d      = miss_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;
`ifdef PRBS_CHECKER_BITCNT_EN
      bit_count_d = bit_count_q;
`endif
      if (din_valid) begin
         case (state_q)
            HUNT: begin
               sr_d   = sr_din;
               fill_d = fill_q + 1'b1;
               if (fill_q == FILL_LAST) begin
                  state_d = VERIFY;
                  run_d   = '0;
               end
            end
            VERIFY: begin
               sr_d = sr_din;
               // An all-ones seed would predict all ones forever, so a stuck-at-1
               // line must never be allowed to verify.
               if (lockup || din != exp_bit) begin
                  state_d = HUNT;
                  fill_d  = '0;
               end else begin
                  run_d = run_q + 1'b1;
                  if (run_q == RUN_LAST) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end
            end
            LOCKED: begin
               sr_d = sr_fly;
`ifdef PRBS_CHECKER_BITCNT_EN
               if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
`endif
               if (din != exp_bit) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                  miss_d = miss_q + 1'b1;
                  if (miss_q == MISS_LAST) begin
                     state_d = HUNT;
                     fill_d  = '0;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: begin
               state_d = HUNT;
               fill_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= HUNT;
         sr_q        <= '0;
         fill_q      <= '0;
         run_q       <= '0;
         miss_q      <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
`ifdef PRBS_CHECKER_BITCNT_EN
         bit_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
`ifdef PRBS_CHECKER_BITCNT_EN
         bit_count_q <= bit_count_d;
`endif
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
`ifdef PRBS_CHECKER_BITCNT_EN
   assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Bench for prbs_xnor_checker: a default instance and an ERR_W=4 instance
// share one directed stimulus stream, checked every cycle against a
// queue-based behavioural model plus hand-computed scenario expectations.
module tb_prbs_xnor_checker;

   localparam int W      = 7;
   localparam int LOCK_N = 16;
   localparam int LOSS_N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        din_valid;
   logic        din;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic        locked4, err_pulse4;
   logic [3:0]  err_count4;
`ifdef PRBS_CHECKER_BITCNT_EN
   logic [15:0] bit_count;
   logic [3:0]  bit_count4;
`endif

   prbs_xnor_checker dut (
      .clk       (clk),
      .reset     (reset),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked),
      .err_pulse (err_pulse),
`ifdef PRBS_CHECKER_BITCNT_EN
      .err_count (err_count),
      .bit_count (bit_count)
`else
      .err_count (err_count)
`endif
   );

   prbs_xnor_checker #(.ERR_W(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked4),
      .err_pulse (err_pulse4),
`ifdef PRBS_CHECKER_BITCNT_EN
      .err_count (err_count4),
      .bit_count (bit_count4)
`else
      .err_count (err_count4)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int sat(input int v, input int bits);
      int mx;
      mx = (1 << bits) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // Reference PRBS7 sequence: s[n] = ~(s[n-7] ^ s[n-6]), generator seeded at 0.
   bit seq [127];

   // Behavioural model: checker history kept as a queue of the last W bits
   // (oldest first), mode 0/1/2 = hunting / verifying / locked.
   int  m_mode, m_fill, m_run, m_miss, m_errs, m_bits;
   bit  m_pulse;
   bit  hist [$];

   always @(posedge clk or posedge reset) begin
      bit e, ones;
      if (reset) begin
         m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0;
         m_errs = 0; m_bits = 0; m_pulse = 0;
         hist.delete();
      end else begin
         m_pulse = 0;
         if (din_valid === 1'b1) begin
            e    = 1'b0;
            ones = 1'b0;
            if (hist.size() == W) begin
               e    = ~(hist[0] ^ hist[1]);
               ones = 1'b1;
               foreach (hist[i]) if (!hist[i]) ones = 1'b0;
            end
            case (m_mode)
               0: begin
                  hist.push_back(din);
                  m_fill++;
                  if (m_fill == W) begin m_mode = 1; m_run = 0; end
               end
               1: begin
                  hist.push_back(din);
                  if (ones || din != e) begin m_mode = 0; m_fill = 0; end
                  else begin
                     m_run++;
                     if (m_run == LOCK_N) begin m_mode = 2; m_miss = 0; end
                  end
               end
               default: begin
                  hist.push_back(e);
                  m_bits++;
                  if (din != e) begin
                     m_errs++;
                     m_pulse = 1;
                     m_miss++;
                     if (m_miss == LOSS_N) begin m_mode = 0; m_fill = 0; end
                  end else m_miss = 0;
               end
            endcase
            while (hist.size() > W) void'(hist.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      check("locked", {31'd0, locked}, {31'd0, m_mode == 2});
      check("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
      check("err_count", {16'd0, err_count}, sat(m_errs, 16));
      check("locked_w4", {31'd0, locked4}, {31'd0, m_mode == 2});
      check("err_pulse_w4", {31'd0, err_pulse4}, {31'd0, m_pulse});
      check("err_count_w4", {28'd0, err_count4}, sat(m_errs, 4));
`ifdef PRBS_CHECKER_BITCNT_EN
      check("bit_count", {16'd0, bit_count}, sat(m_bits, 16));
      check("bit_count_w4", {28'd0, bit_count4}, sat(m_bits, 4));
`endif
   end

   int p;
   int idle_pulses;

   task automatic step(input logic v, input logic d);
      din_valid = v;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int gap);
      repeat (gap) begin
         step(1'b0, 1'($urandom_range(0, 1)));
         if (err_pulse !== 1'b0 || err_pulse4 !== 1'b0) idle_pulses++;
      end
   endtask

   task automatic send_clean(input int n, input int gap);
      repeat (n) begin
         step(1'b1, seq[p % 127]);
         p++;
         idle(gap);
      end
   endtask

   task automatic send_err();
      step(1'b1, ~seq[p % 127]);
      p++;
   endtask

   task automatic send_until_lock(input int gap, output int n);
      n = 0;
      while (locked !== 1'b1 && n < 100) begin
         step(1'b1, seq[p % 127]);
         p++;
         n++;
         idle(gap);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      reset = 1'b0;
      p = 0;
   endtask

   initial begin
      int  n;
      bit  seen_lock;
      logic [6:0] first7;

      reset     = 1'b1;
      din_valid = 1'b0;
      din       = 1'b0;
      idle_pulses = 0;

      for (int i = 0; i < 127; i++) begin
         bit a, b;
         a = (i >= 7) ? seq[i-7] : 1'b0;
         b = (i >= 6) ? seq[i-6] : 1'b0;
         seq[i] = ~(a ^ b);
      end
      for (int i = 0; i < 7; i++) first7[6-i] = seq[i];
      check("prbs_first_bits", {25'd0, first7}, 32'b1111110);
      check("prbs_bit13", {31'd0, seq[13]}, 32'd0);

      // 1: clean stream from reset
      do_reset();
      check("reset_locked", {31'd0, locked}, 32'd0);
      check("reset_err_count", {16'd0, err_count}, 32'd0);
      send_until_lock(0, n);
      check("lock_latency", n, 32'd23);
      send_clean(500 - 23, 0);
      check("s1_err_count", {16'd0, err_count}, 32'd0);
`ifdef PRBS_CHECKER_BITCNT_EN
      check("s1_bit_count", {16'd0, bit_count}, 32'd477);
      check("s1_bit_count_w4", {28'd0, bit_count4}, 32'd15);
`endif

      // 2: single error, flywheel holds lock
      send_clean(299, 0);
      send_err();
      check("s2_err_pulse", {31'd0, err_pulse}, 32'd1);
      check("s2_err_count", {16'd0, err_count}, 32'd1);
      check("s2_locked", {31'd0, locked}, 32'd1);
      send_clean(1, 0);
      check("s2_pulse_once", {31'd0, err_pulse}, 32'd0);
      send_clean(199, 0);
      check("s2_err_count_after", {16'd0, err_count}, 32'd1);
      check("s2_locked_after", {31'd0, locked}, 32'd1);

      // 3: LOSS_N consecutive errors drop lock; one error carried from step 2
      repeat (3) send_err();
      check("s3_locked_3err", {31'd0, locked}, 32'd1);
      send_err();
      check("s3_locked_4err", {31'd0, locked}, 32'd0);
      check("s3_err_count", {16'd0, err_count}, 32'd5);
      send_until_lock(0, n);
      check("s3_relock_latency", n, 32'd23);
      check("s3_err_count_kept", {16'd0, err_count}, 32'd5);

      // 4: constant lines never lock
      do_reset();
      seen_lock = 1'b0;
      repeat (200) begin step(1'b1, 1'b1); if (locked !== 1'b0) seen_lock = 1'b1; end
      repeat (200) begin step(1'b1, 1'b0); if (locked !== 1'b0) seen_lock = 1'b1; end
      check("s4_never_locked", {31'd0, seen_lock}, 32'd0);
      check("s4_err_count", {16'd0, err_count}, 32'd0);

      // 5: one valid cycle in three, then 20 isolated errors
      do_reset();
      idle_pulses = 0;
      send_until_lock(2, n);
      check("s5_lock_latency", n, 32'd23);
      for (int k = 0; k < 20; k++) begin
         send_clean(9, 2);
         send_err();
         idle(2);
      end
      check("s5_locked", {31'd0, locked}, 32'd1);
      check("s5_err_count", {16'd0, err_count}, 32'd20);
      check("s5_err_count_sat", {28'd0, err_count4}, 32'd15);
      check("s5_idle_pulses", idle_pulses, 32'd0);

      // 6: asynchronous reset between edges while locked
      #2;
      reset = 1'b1;
      #1;
      check("s6_locked", {31'd0, locked}, 32'd0);
      check("s6_err_count", {16'd0, err_count}, 32'd0);
      check("s6_err_count_w4", {28'd0, err_count4}, 32'd0);
`ifdef PRBS_CHECKER_BITCNT_EN
      check("s6_bit_count", {16'd0, bit_count}, 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      p = 0;
      send_until_lock(0, n);
      check("s6_relock_latency", n, 32'd23);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
